// File: rtl/dmem_dump_arbiter_pkg.sv
// Shared constants and types for the data-RAM dump arbiter.
//   DataW     : data RAM word width
//   RamDepth  : data RAM depth in words
//   RamAddrW  : data RAM word-address width
//   dump_state_e : arbiter FSM states
package dmem_dump_arbiter_pkg;

  localparam int unsigned DataW    = 32;
  localparam int unsigned RamDepth = 2048;
  localparam int unsigned RamAddrW = $clog2(RamDepth);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCapture,
    StHold,
    StDone
  } dump_state_e;

endpackage

// File: rtl/dmem_dump_arbiter.sv
// Owns the single port of the data RAM and shares it between the MEM stage and the
// debug unit. In idle the pipeline drives the RAM combinationally. Once halted, a
// dump request takes the port, reads a contiguous word range (wrapping at the top
// of the RAM) and streams each word out on a valid/ready handshake.
//
// Ports:
//   clk, reset           : clock, asynchronous active-low reset
//   halt_flag            : pipeline halted; gates dump acceptance only
//   pipe_*               : MEM-stage RAM request and read data (pipe_stall while dumping)
//   dump_start/base/count: one-cycle dump request, first word, word count (0..2048)
//   dump_busy/dump_done  : dump in progress / one-cycle completion pulse
//   dbg_valid/ready/data/last : word stream to the debug unit
//   ram_*                : RAM port (1-cycle read latency)
module dmem_dump_arbiter
  import dmem_dump_arbiter_pkg::*;
#(
  parameter int unsigned len    = DataW,
  parameter int unsigned ADDR_W = RamAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt_flag,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [len-1:0]    pipe_wdata,
  input  logic              pipe_we,
  input  logic              pipe_re,
  output logic [len-1:0]    pipe_rdata,
  output logic              pipe_stall,
  input  logic              dump_start,
  input  logic [ADDR_W-1:0] dump_base,
  input  logic [ADDR_W:0]   dump_count,
  output logic              dump_busy,
  output logic              dump_done,
  output logic              dbg_valid,
  input  logic              dbg_ready,
  output logic [len-1:0]    dbg_data,
  output logic              dbg_last,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [len-1:0]    ram_din,
  output logic              ram_we,
  output logic              ram_en,
  input  logic [len-1:0]    ram_dout
);

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   remaining_q, remaining_d;
  logic [len-1:0]    dbg_data_q, dbg_data_d;
  logic              dbg_valid_q, dbg_valid_d;
  logic              dbg_last_q, dbg_last_d;

  logic last_word;
  assign last_word = (remaining_q == (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      remaining_q <= '0;
      dbg_data_q  <= '0;
      dbg_valid_q <= 1'b0;
      dbg_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      dbg_data_q  <= dbg_data_d;
      dbg_valid_q <= dbg_valid_d;
      dbg_last_q  <= dbg_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    dbg_data_d  = dbg_data_q;
    dbg_valid_d = dbg_valid_q;
    dbg_last_d  = dbg_last_q;

    // Dump owns the port by default; idle hands it back to the pipeline.
    ram_addr   = ptr_q;
    ram_din    = '0;
    ram_we     = 1'b0;
    ram_en     = 1'b0;
    pipe_stall = 1'b1;
    dump_busy  = 1'b1;
    dump_done  = 1'b0;

    unique case (state_q)
      StIdle: begin
        ram_addr   = pipe_addr;
        ram_din    = pipe_wdata;
        ram_we     = pipe_we;
        ram_en     = pipe_re | pipe_we;
        pipe_stall = 1'b0;
        dump_busy  = 1'b0;
        if (dump_start && halt_flag) begin
          ptr_d       = dump_base;
          remaining_d = dump_count;
          state_d     = (dump_count == '0) ? StDone : StIssue;
        end
      end
      StIssue: begin
        ram_en  = 1'b1;
        state_d = StCapture;
      end
      StCapture: begin
        dbg_data_d  = ram_dout;
        dbg_valid_d = 1'b1;
        dbg_last_d  = last_word;
        state_d     = StHold;
      end
      StHold: begin
        if (dbg_ready) begin
          dbg_valid_d = 1'b0;
          ptr_d       = ptr_q + ADDR_W'(1);  // wraps at the top of the RAM
          remaining_d = remaining_q - (ADDR_W+1)'(1);
          state_d     = last_word ? StDone : StIssue;
        end
      end
      StDone: begin
        dump_done = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign pipe_rdata = ram_dout;
  assign dbg_data   = dbg_data_q;
  assign dbg_valid  = dbg_valid_q;
  assign dbg_last   = dbg_last_q;

endmodule

// File: tb/tb_dmem_dump_arbiter.sv
// Self-checking bench for dmem_dump_arbiter with a behavioural 2048x32 RAM model
// and a scoreboard of expected dump words.
module tb_dmem_dump_arbiter;

  localparam int unsigned Len   = 32;
  localparam int unsigned AddrW = 11;
  localparam int unsigned Depth = 2048;

  logic             clk = 1'b0;
  logic             reset;
  logic             halt_flag;
  logic [AddrW-1:0] pipe_addr;
  logic [Len-1:0]   pipe_wdata;
  logic             pipe_we;
  logic             pipe_re;
  logic [Len-1:0]   pipe_rdata;
  logic             pipe_stall;
  logic             dump_start;
  logic [AddrW-1:0] dump_base;
  logic [AddrW:0]   dump_count;
  logic             dump_busy;
  logic             dump_done;
  logic             dbg_valid;
  logic             dbg_ready;
  logic [Len-1:0]   dbg_data;
  logic             dbg_last;
  logic [AddrW-1:0] ram_addr;
  logic [Len-1:0]   ram_din;
  logic             ram_we;
  logic             ram_en;
  logic [Len-1:0]   ram_dout;

  dmem_dump_arbiter #(.len(Len), .ADDR_W(AddrW)) dut (
    .clk        (clk),
    .reset      (reset),
    .halt_flag  (halt_flag),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_we    (pipe_we),
    .pipe_re    (pipe_re),
    .pipe_rdata (pipe_rdata),
    .pipe_stall (pipe_stall),
    .dump_start (dump_start),
    .dump_base  (dump_base),
    .dump_count (dump_count),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done),
    .dbg_valid  (dbg_valid),
    .dbg_ready  (dbg_ready),
    .dbg_data   (dbg_data),
    .dbg_last   (dbg_last),
    .ram_addr   (ram_addr),
    .ram_din    (ram_din),
    .ram_we     (ram_we),
    .ram_en     (ram_en),
    .ram_dout   (ram_dout)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous, read-first, 1-cycle read latency.
  logic [Len-1:0] mem [Depth];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct packed {
    logic [Len-1:0] data;
    logic           last;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each handshake and checks hold stability.
  int             words_seen = 0;
  logic           prev_stall = 1'b0;
  logic [Len-1:0] prev_data  = '0;
  exp_t           popped;

  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", 64'(dbg_valid), 64'd1);
        check_eq("hold_data", 64'(dbg_data), 64'(prev_data));
      end
      if (dbg_valid && dbg_ready) begin
        if (sb.size() == 0) begin
          check_eq("extra_word", 64'(sb.size() != 0), 64'd1);
        end else begin
          popped = sb.pop_front();
          check_eq("dbg_data", 64'(dbg_data), 64'(popped.data));
          check_eq("dbg_last", 64'(dbg_last), 64'(popped.last));
        end
        words_seen++;
      end
      prev_stall = dbg_valid && !dbg_ready;
      prev_data  = dbg_data;
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"}, 64'(dump_busy), 64'd0);
    check_eq({tag, "_stall"}, 64'(pipe_stall), 64'd0);
    check_eq({tag, "_done"}, 64'(dump_done), 64'd0);
    check_eq({tag, "_valid"}, 64'(dbg_valid), 64'd0);
    check_eq({tag, "_last"}, 64'(dbg_last), 64'd0);
    check_eq({tag, "_data"}, 64'(dbg_data), 64'd0);
    check_eq({tag, "_ram_en"}, 64'(ram_en), 64'd0);
    check_eq({tag, "_ram_we"}, 64'(ram_we), 64'd0);
  endtask

  // Runs one dump; dbg_ready drops for stall_len cycles while word stall_idx is held.
  task automatic run_dump(input int base, input int count, input int stall_idx,
                          input int stall_len);
    int k, stall_ctr, first_valid, done_at, busy_cnt, exp_cycles;
    for (int i = 0; i < count; i++) begin
      sb.push_back(exp_t'{data: mem[(base + i) % Depth], last: (i == count - 1)});
    end
    words_seen  = 0;
    stall_ctr   = 0;
    first_valid = 0;
    done_at     = 0;
    busy_cnt    = 0;
    exp_cycles  = 3 * count + 1 + ((stall_idx < count) ? stall_len : 0);
    @(posedge clk); #1;
    halt_flag  = 1'b1;
    dump_base  = AddrW'(base);
    dump_count = (AddrW+1)'(count);
    dump_start = 1'b1;
    dbg_ready  = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    // Pipeline noise during the dump must never reach the RAM.
    pipe_addr  = 11'd7;
    pipe_wdata = 32'hBAD0_BAD0;
    pipe_we    = 1'b1;
    pipe_re    = 1'b1;
    k = 1;
    while (k <= 300) begin
      if (dbg_valid && words_seen == stall_idx && stall_ctr < stall_len) begin
        dbg_ready = 1'b0;
        stall_ctr++;
      end else begin
        dbg_ready = 1'b1;
      end
      if (k == 1) begin
        check_eq("dump_stall", 64'(pipe_stall), 64'd1);
        check_eq("dump_ram_we", 64'(ram_we), 64'd0);
        check_eq("dump_ram_en", 64'(ram_en), 64'(count != 0));
        if (count != 0) check_eq("dump_ram_addr", 64'(ram_addr), 64'(base));
      end
      if (k == 4) halt_flag = 1'b0;  // dump must finish regardless
      // A second request while busy must be ignored.
      if (k == 5) begin
        dump_base  = 11'd100;
        dump_count = 12'd3;
        dump_start = 1'b1;
      end else begin
        dump_start = 1'b0;
      end
      if (dbg_valid && first_valid == 0) first_valid = k;
      if (dump_done) done_at = k;
      if (!dump_busy) break;
      busy_cnt++;
      @(posedge clk); #1;
      k++;
    end
    dump_start = 1'b0;
    pipe_we    = 1'b0;
    pipe_re    = 1'b0;
    pipe_addr  = '0;
    pipe_wdata = '0;
    halt_flag  = 1'b1;
    if (k > 300) check_eq("dump_timeout", 64'(k), 64'd300);
    check_eq("words_seen", 64'(words_seen), 64'(count));
    check_eq("sb_drained", 64'(sb.size()), 64'd0);
    check_eq("done_at", 64'(done_at), 64'(exp_cycles));
    check_eq("busy_cycles", 64'(busy_cnt), 64'(exp_cycles));
    check_eq("first_valid", 64'(first_valid), 64'((count == 0) ? 0 : 3));
    sb.delete();
  endtask

  initial begin
    reset      = 1'b0;
    halt_flag  = 1'b0;
    pipe_addr  = '0;
    pipe_wdata = '0;
    pipe_we    = 1'b0;
    pipe_re    = 1'b0;
    dump_start = 1'b0;
    dump_base  = '0;
    dump_count = '0;
    dbg_ready  = 1'b0;
    for (int i = 0; i < Depth; i++) mem[i] = 32'(i * 3 + 32'h1000);
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    mem[Depth-1] = 32'hA5A5_0FFF;

    #12;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // Passthrough write then read of address 5.
    pipe_addr  = 11'd5;
    pipe_wdata = 32'hDEAD_BEEF;
    pipe_we    = 1'b1;
    #1;
    check_eq("pt_ram_addr", 64'(ram_addr), 64'd5);
    check_eq("pt_ram_din", 64'(ram_din), 64'hDEAD_BEEF);
    check_eq("pt_ram_we", 64'(ram_we), 64'd1);
    check_eq("pt_ram_en", 64'(ram_en), 64'd1);
    check_eq("pt_stall_w", 64'(pipe_stall), 64'd0);
    @(posedge clk); #1;
    pipe_we = 1'b0;
    pipe_re = 1'b1;
    #1;
    check_eq("pt_ram_we_rd", 64'(ram_we), 64'd0);
    @(posedge clk); #1;
    pipe_re = 1'b0;
    check_eq("pt_rdata", 64'(pipe_rdata), 64'hDEAD_BEEF);
    check_eq("pt_stall_r", 64'(pipe_stall), 64'd0);

    // Start while not halted is ignored.
    dump_base  = '0;
    dump_count = 12'd4;
    dump_start = 1'b1;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("gated_busy", 64'(dump_busy), 64'd0);
      check_eq("gated_valid", 64'(dbg_valid), 64'd0);
      @(posedge clk); #1;
    end

    run_dump(0, 4, 99, 0);       // full rate
    run_dump(0, 4, 1, 5);        // backpressure on word 2
    run_dump(Depth - 1, 2, 99, 0);  // wrap 2047 -> 0
    run_dump(0, 0, 99, 0);       // zero count

    // Reset while holding a word.
    @(posedge clk); #1;
    halt_flag  = 1'b1;
    dump_base  = '0;
    dump_count = 12'd4;
    dump_start = 1'b1;
    dbg_ready  = 1'b0;
    @(posedge clk); #1;
    dump_start = 1'b0;
    for (int i = 0; i < 20 && !dbg_valid; i++) begin
      @(posedge clk); #1;
    end
    check_eq("rst_reached_hold", 64'(dbg_valid), 64'd1);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_eq("rst_rel_stall", 64'(pipe_stall), 64'd0);
    check_eq("rst_rel_valid", 64'(dbg_valid), 64'd0);
    run_dump(0, 4, 99, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
